updown_counter_param: RTL and testbench
=======================================

Name: updown_counter_param

Overview:
Parametrised up/down counter, successor to the team's fixed 4-bit up/down counter. Adds a configurable width, an enable, a programmable step and upper limit, parallel load, and wrap or saturate mode. It also reports overflow and underflow through a terminal-count pulse and sticky flags. Used as a general event, position or address counter in datapath and control blocks.

Parameters:
WIDTH, 8, counter, load value and limit width in bits (≥2)
STEP_W, 4, step input width in bits (1..WIDTH)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  count enable; one step per cycle while high
updown  input  1  1 = count up, 0 = count down
step  input  STEP_W  increment/decrement magnitude, unsigned
limit  input  WIDTH  inclusive upper bound of count range (0..limit)
sat_mode  input  1  1 = saturate at bounds, 0 = wrap modulo limit+1
load  input  1  parallel load strobe
load_val  input  WIDTH  value loaded when load=1
clr_flags  input  1  clears ovf_sticky and unf_sticky
count  output  WIDTH  current count, registered
tc  output  1  registered 1-cycle pulse: an overflow or underflow event occurred on the previous edge
ovf_sticky  output  1  set by any up overflow event
unf_sticky  output  1  set by any down underflow event
at_max  output  1  combinational, count == limit
at_zero  output  1  combinational, count == 0

Behaviour:
- Reset: synchronous, active-high, highest priority. Sets count=0, tc=0, ovf_sticky=0, unf_sticky=0.
- Priority per edge: rst > load > en. With en=0 and load=0, count holds and tc=0.
- Load: count <= min(load_val, limit). Load produces no tc and no flag changes, even if en=1.
- Effective step s is min(step, limit), zero-extended. All arithmetic uses WIDTH+1 bits so intermediate results cannot truncate.
- s=0 with en=1: count holds, no event.
- Out-of-range state: if en=1 and count > limit (limit lowered at runtime), count <= 0 when counting up and count <= limit when counting down. This raises no event.
- Up, normal case (count+s ≤ limit): count <= count+s.
- Up, overflow case (count+s > limit): this is an overflow event.
  - Wrap mode: count <= count+s-(limit+1).
  - Saturate mode: count <= limit.
- Down, normal case (count ≥ s): count <= count-s.
- Down, underflow case (count < s): this is an underflow event.
  - Wrap mode: count <= count+(limit+1)-s.
  - Saturate mode: count <= 0.
- Saturate mode at a bound (e.g. count=limit, up): every further enabled step is an overflow event. tc re-pulses and count stays.
- limit=0: count is always 0. Every enabled step with step≠0 is an event.
- tc: registered. High in exactly the cycle following an event edge, otherwise 0.
- Sticky flags: set on their event. Cleared by clr_flags. If set and clear coincide on the same edge, set wins.
- Latency: count reflects en/load/updown one edge after sampling. at_max and at_zero follow count with zero delay.
- The step input, mode and limit may change every cycle. Each edge uses the values sampled at that edge.

Test Plan:
- Reset/basic count: rst=1 for 1 cycle, then en=1, updown=1, step=1, limit=255, 5 cycles -> count 0,1,2,3,4,5; tc=0; flags=0.
- Wrap up with step: limit=9, sat_mode=0, load 7, then en up step=3 -> count 0 (7+3-10). Next cycle tc=1, ovf_sticky=1. Next step -> count 3, tc=0.
- Wrap down / saturate: limit=9, count=1, down step=3, wrap -> count 8, unf_sticky=1. Repeat with sat_mode=1 -> count 0; a second step keeps count 0 and pulses tc again.
- Priority/load clamp: same edge load=1, load_val=200, limit=100, en=1, updown=1 -> count 100, tc=0. Assert rst together with load -> count 0.
- Flags set-vs-clear: overflow event and clr_flags=1 on the same edge -> ovf_sticky=1. clr_flags alone on the next edge -> 0. unf_sticky unaffected.
- Limit lowered mid-run: count=50, limit changed to 20, en up -> count 0 with no tc. Then with limit=20, step=30, up from 0 -> s=20, count 20, at_max=1.

Source files
------------

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with enable, programmable step and upper
// limit, parallel load, and wrap or saturate behaviour at the range bounds.
// Overflow and underflow events produce a registered one-cycle tc pulse and
// set sticky flags.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous, active-high reset (count, tc and flags to 0)
//   en         - count enable, one step per cycle while high
//   updown     - 1 = count up, 0 = count down
//   step       - unsigned step magnitude (clamped to limit)
//   limit      - inclusive upper bound of the count range 0..limit
//   sat_mode   - 1 = saturate at the bounds, 0 = wrap modulo limit+1
//   load       - parallel load strobe (beats en)
//   load_val   - value loaded on load, clamped to limit
//   clr_flags  - clears both sticky flags (a coincident set wins)
//   count      - current count, registered
//   tc         - one-cycle pulse after an overflow/underflow edge
//   ovf_sticky - set by any up overflow event
//   unf_sticky - set by any down underflow event
//   at_max     - combinational, count == limit
//   at_zero    - combinational, count == 0
module updown_counter_param #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              updown,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic              sat_mode,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              ovf_sticky,
    output logic              unf_sticky,
    output logic              at_max,
    output logic              at_zero
);

    // One extra bit so count+step and limit+1 never truncate.
    localparam int EW = WIDTH + 1;
    localparam logic [EW-1:0] ONE_E = EW'(1);

    logic [WIDTH-1:0] count_p0;
    logic             tc_p0;
    logic             ovf_p0;
    logic             unf_p0;

    logic [EW-1:0]    cnt_e;
    logic [EW-1:0]    lim_e;
    logic [EW-1:0]    step_e;
    logic [EW-1:0]    s_e;
    logic [EW-1:0]    sum_e;
    logic [WIDTH-1:0] nxt;
    logic             ovf_ev;
    logic             unf_ev;

    function automatic logic [EW-1:0] clamp_to(input logic [EW-1:0] a,
                                               input logic [EW-1:0] b);
        return (a > b) ? b : a;
    endfunction

    assign cnt_e  = {1'b0, count_p0};
    assign lim_e  = {1'b0, limit};
    assign step_e = {{(EW-STEP_W){1'b0}}, step};
    assign s_e    = clamp_to(step_e, lim_e);
    assign sum_e  = cnt_e + s_e;

    always_comb begin
        nxt    = count_p0;
        ovf_ev = 1'b0;
        unf_ev = 1'b0;
        if (load) begin
            nxt = WIDTH'(clamp_to({1'b0, load_val}, lim_e));
        end else if (en) begin
            if (cnt_e > lim_e) begin
                // Limit was lowered below the current count: re-enter the
                // range at the bound we are heading away from, silently.
                nxt = updown ? '0 : limit;
            end else if (lim_e == '0) begin
                // Degenerate range: s clamps to 0, yet any nonzero request
                // still crosses the single-value range.
                nxt    = '0;
                ovf_ev = updown && (step != '0);
                unf_ev = !updown && (step != '0);
            end else if (s_e == '0) begin
                nxt = count_p0;
            end else if (updown) begin
                if (sum_e > lim_e) begin
                    ovf_ev = 1'b1;
                    nxt    = sat_mode ? limit : WIDTH'(sum_e - lim_e - ONE_E);
                end else begin
                    nxt = WIDTH'(sum_e);
                end
            end else begin
                if (cnt_e >= s_e) begin
                    nxt = WIDTH'(cnt_e - s_e);
                end else begin
                    unf_ev = 1'b1;
                    nxt    = sat_mode ? '0 : WIDTH'(cnt_e + (lim_e - s_e) + ONE_E);
                end
            end
        end
    end

    // Stage p0: registered count, event pulse and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            count_p0 <= '0;
            tc_p0    <= 1'b0;
            ovf_p0   <= 1'b0;
            unf_p0   <= 1'b0;
        end else begin
            count_p0 <= nxt;
            tc_p0    <= ovf_ev | unf_ev;
            if (ovf_ev)         ovf_p0 <= 1'b1;
            else if (clr_flags) ovf_p0 <= 1'b0;
            if (unf_ev)         unf_p0 <= 1'b1;
            else if (clr_flags) unf_p0 <= 1'b0;
        end
    end

    assign count      = count_p0;
    assign tc         = tc_p0;
    assign ovf_sticky = ovf_p0;
    assign unf_sticky = unf_p0;
    assign at_max     = (count_p0 == limit);
    assign at_zero    = (count_p0 == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
module tb_updown_counter_param;

    localparam int W  = 8;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          updown = 1'b1;
    logic [SW-1:0] step = '0;
    logic [W-1:0]  limit = 8'd255;
    logic          sat_mode = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic          clr_flags = 1'b0;
    logic [W-1:0]  count;
    logic          tc, ovf_sticky, unf_sticky, at_max, at_zero;

    int total = 0;
    int bad   = 0;

    // Reference state, plain integers
    int m_cnt = 0;
    int m_tc  = 0;
    int m_ovf = 0;
    int m_unf = 0;

    updown_counter_param #(.WIDTH(W), .STEP_W(SW)) dut (
        .clk(clk), .rst(rst), .en(en), .updown(updown), .step(step),
        .limit(limit), .sat_mode(sat_mode), .load(load), .load_val(load_val),
        .clr_flags(clr_flags), .count(count), .tc(tc),
        .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky),
        .at_max(at_max), .at_zero(at_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply the counting rules to the inputs present at this edge.
    task automatic model_edge();
        int lim, st, s, ev_o, ev_u;
        lim  = int'(limit);
        st   = int'(step);
        s    = (st < lim) ? st : lim;
        ev_o = 0;
        ev_u = 0;
        if (rst) begin
            m_cnt = 0; m_tc = 0; m_ovf = 0; m_unf = 0;
        end else begin
            if (load) begin
                m_cnt = (int'(load_val) < lim) ? int'(load_val) : lim;
            end else if (en) begin
                if (m_cnt > lim) begin
                    m_cnt = updown ? 0 : lim;
                end else if (lim == 0) begin
                    m_cnt = 0;
                    if (st != 0) begin
                        if (updown) ev_o = 1; else ev_u = 1;
                    end
                end else if (s != 0) begin
                    if (updown) begin
                        if (m_cnt + s <= lim) m_cnt = m_cnt + s;
                        else begin
                            ev_o = 1;
                            m_cnt = sat_mode ? lim : (m_cnt + s) % (lim + 1);
                        end
                    end else begin
                        if (m_cnt >= s) m_cnt = m_cnt - s;
                        else begin
                            ev_u = 1;
                            m_cnt = sat_mode ? 0 : m_cnt + lim + 1 - s;
                        end
                    end
                end
            end
            m_tc = (ev_o | ev_u);
            if (ev_o != 0) m_ovf = 1; else if (clr_flags) m_ovf = 0;
            if (ev_u != 0) m_unf = 1; else if (clr_flags) m_unf = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("count",   int'(count),      m_cnt);
        chk("tc",      int'(tc),         m_tc);
        chk("ovf",     int'(ovf_sticky), m_ovf);
        chk("unf",     int'(unf_sticky), m_unf);
        chk("at_max",  int'(at_max),     (m_cnt == int'(limit)) ? 1 : 0);
        chk("at_zero", int'(at_zero),    (m_cnt == 0) ? 1 : 0);
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_val = W'(v); en = 1'b0;
        tick();
        load = 1'b0;
    endtask

    initial begin
        // Reset and basic up count
        rst = 1'b1;
        tick();
        chk("rst_count", int'(count), 0);
        rst = 1'b0; en = 1'b1; updown = 1'b1; step = SW'(1); limit = 8'd255;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("basic_cnt", int'(count), i);
        end

        // Wrap up with step 3, limit 9
        limit = 8'd9; sat_mode = 1'b0;
        do_load(7);
        en = 1'b1; updown = 1'b1; step = SW'(3);
        tick();
        chk("wrap_up_cnt", int'(count), 0);
        chk("wrap_up_tc", int'(tc), 1);
        chk("wrap_up_ovf", int'(ovf_sticky), 1);
        tick();
        chk("wrap_up_cnt2", int'(count), 3);
        chk("wrap_up_tc2", int'(tc), 0);

        // Wrap down, then saturate down
        do_load(1);
        en = 1'b1; updown = 1'b0; step = SW'(3);
        tick();
        chk("wrap_dn_cnt", int'(count), 8);
        chk("wrap_dn_unf", int'(unf_sticky), 1);
        do_load(1);
        sat_mode = 1'b1; en = 1'b1; updown = 1'b0;
        tick();
        chk("sat_dn_cnt", int'(count), 0);
        tick();
        chk("sat_dn_cnt2", int'(count), 0);
        chk("sat_dn_tc2", int'(tc), 1);

        // Load clamp beats enable; reset beats load
        limit = 8'd100; load = 1'b1; load_val = 8'd200; en = 1'b1; updown = 1'b1;
        tick();
        chk("load_clamp", int'(count), 100);
        chk("load_tc", int'(tc), 0);
        rst = 1'b1;
        tick();
        chk("rst_vs_load", int'(count), 0);
        rst = 1'b0; load = 1'b0;

        // Sticky set wins over clear
        limit = 8'd9; sat_mode = 1'b1; en = 1'b1; updown = 1'b0; step = SW'(1);
        tick();
        chk("unf_set", int'(unf_sticky), 1);
        do_load(9);
        en = 1'b1; updown = 1'b1; clr_flags = 1'b1;
        tick();
        chk("set_wins", int'(ovf_sticky), 1);
        en = 1'b0;
        tick();
        chk("clr_ovf", int'(ovf_sticky), 0);
        clr_flags = 1'b0;

        // Limit lowered below the count
        limit = 8'd255;
        do_load(50);
        limit = 8'd20; en = 1'b1; updown = 1'b1; step = SW'(1);
        tick();
        chk("oor_cnt", int'(count), 0);
        chk("oor_tc", int'(tc), 0);
        step = SW'(30);
        tick();
        chk("clamp_step", int'(count), 20);
        chk("clamp_atmax", int'(at_max), 1);

        // Degenerate limit 0
        limit = 8'd0; step = SW'(2); updown = 1'b0;
        tick();
        tick();
        chk("lim0_tc", int'(tc), 1);

        // Randomised run
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            load      = ($urandom_range(0, 7) == 0);
            en        = ($urandom_range(0, 3) != 0);
            updown    = 1'($urandom_range(0, 1));
            sat_mode  = 1'($urandom_range(0, 1));
            clr_flags = ($urandom_range(0, 7) == 0);
            step      = SW'($urandom_range(0, 31));
            load_val  = W'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0)
                limit = W'($urandom_range(0, 255));
            else if ($urandom_range(0, 15) == 0)
                limit = W'($urandom_range(0, 3));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
